// File: rtl/melody_tone_gen.sv
// Note-RAM melody sequencer with square-wave tone synthesis feeding the I2S serializer.
// Each entry is {half-period divider, beat count}; beats == 0 marks the end of the song.
//
//  state | meaning
//  ------+--------------------------------------------------------------
//  IDLE  | no playback, audio held at 0
//  FETCH | one-cycle read of the note RAM at step_idx, audio gap
//  PLAY  | square wave for beats * BEAT_CYCLES cycles
module melody_tone_gen #(
    parameter int          BEAT_CYCLES = 25_000_000,
    parameter int          DEPTH       = 32,
    parameter logic [15:0] AMP_BASE    = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [23:0] wr_data,
    input  logic        start,
    input  logic        stop,
    input  logic        loop,
    input  logic [2:0]  volume,
    output logic [15:0] audio_left,
    output logic [15:0] audio_right,
    output logic        busy,
    output logic [4:0]  step_idx,
    output logic        done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] PLAY  = 2'd2;

    localparam logic [4:0] LAST_STEP = 5'(DEPTH - 1);

    logic [1:0]  state;
    logic [23:0] mem [DEPTH];
    logic [23:0] rd_word;
    logic [19:0] note_div;
    logic [19:0] half_cnt;
    logic        phase;
    logic [31:0] play_cnt;
    logic [15:0] amp;

    // Unregistered read: a write on the same edge lands after this value is consumed.
    assign rd_word = mem[step_idx];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        amp = '0;
        case (volume)
            3'd0:    amp = '0;
            3'd1:    amp = AMP_BASE;
            3'd2:    amp = AMP_BASE << 1;
            3'd3:    amp = AMP_BASE << 2;
            default: amp = AMP_BASE << 3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            step_idx   <= '0;
            done       <= 1'b0;
            audio_left <= '0;
            note_div   <= '0;
            half_cnt   <= '0;
            phase      <= 1'b0;
            play_cnt   <= '0;
        end else begin
            done       <= 1'b0;
            audio_left <= '0;
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        state    <= FETCH;
                        step_idx <= '0;
                        busy     <= 1'b1;
                    end
                end
                FETCH: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (rd_word[3:0] == 4'd0) begin
                        if (loop) begin
                            step_idx <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        note_div <= rd_word[23:4];
                        play_cnt <= 32'(rd_word[3:0]) * 32'(BEAT_CYCLES) - 32'd1;
                        half_cnt <= '0;
                        phase    <= 1'b1;
                        state    <= PLAY;
                    end
                end
                PLAY: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        if (note_div != 20'd0) begin
                            audio_left <= phase ? amp : -amp;
                            if (half_cnt == note_div - 20'd1) begin
                                half_cnt <= '0;
                                phase    <= ~phase;
                            end else begin
                                half_cnt <= half_cnt + 20'd1;
                            end
                        end
                        // Running off the last entry behaves like hitting an end marker.
                        if (play_cnt == 32'd0) begin
                            if (step_idx == LAST_STEP) begin
                                if (loop) begin
                                    step_idx <= '0;
                                    state    <= FETCH;
                                end else begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end
                            end else begin
                                step_idx <= step_idx + 5'd1;
                                state    <= FETCH;
                            end
                        end else begin
                            play_cnt <= play_cnt - 32'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign audio_right = audio_left;

endmodule

// File: tb/tb_melody_tone_gen.sv
// Bench for melody_tone_gen: directed songs plus random songs checked against a
// per-cycle expectation list derived from the note table.
module tb_melody_tone_gen;

    localparam int BC = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [23:0] wr_data;
    logic        start;
    logic        stop;
    logic        loop;
    logic [2:0]  volume;
    logic [15:0] audio_left;
    logic [15:0] audio_right;
    logic        busy;
    logic [4:0]  step_idx;
    logic        done;

    always #5 clk = ~clk;

    melody_tone_gen #(.BEAT_CYCLES(BC)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .stop(stop), .loop(loop), .volume(volume),
        .audio_left(audio_left), .audio_right(audio_right),
        .busy(busy), .step_idx(step_idx), .done(done)
    );

    typedef struct {
        logic [15:0] audio;
        logic        busy;
        logic [4:0]  step;
        logic        done;
    } rec_t;

    rec_t        exp_q[$];
    logic [23:0] ram_m [32];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] amp_of(input int v);
        int vv;
        vv = (v > 4) ? 4 : v;
        if (v == 0) return 16'd0;
        return 16'h0800 << (vv - 1);
    endfunction

    task automatic push(input logic [15:0] a, input logic b, input int s, input logic d);
        rec_t r;
        r.audio = a;
        r.busy  = b;
        r.step  = 5'(s);
        r.done  = d;
        exp_q.push_back(r);
    endtask

    task automatic wr(input int addr, input int dv, input int beats);
        wr_en   = 1'b1;
        wr_addr = 5'(addr);
        wr_data = {20'(dv), 4'(beats)};
        ram_m[addr] = {20'(dv), 4'(beats)};
        tick();
        wr_en = 1'b0;
    endtask

    // Expected outputs after each edge, starting with the edge that samples start.
    task automatic build(input bit lp, input int vol, input int max_rec);
        int s;
        int b;
        int dv;
        int len;
        logic [15:0] amp;
        logic [15:0] a;
        s   = 0;
        amp = amp_of(vol);
        exp_q.delete();
        push(16'd0, 1'b1, 0, 1'b0);
        while (exp_q.size() < max_rec) begin
            b  = int'(ram_m[s][3:0]);
            dv = int'(ram_m[s][23:4]);
            if (b == 0) begin
                if (lp) begin
                    push(16'd0, 1'b1, 0, 1'b0);
                    s = 0;
                    continue;
                end
                push(16'd0, 1'b0, 0, 1'b1);
                push(16'd0, 1'b0, 0, 1'b0);
                return;
            end
            push(16'd0, 1'b1, s, 1'b0);
            len = b * BC;
            for (int i = 0; i < len; i++) begin
                if (dv == 0) a = 16'd0;
                else if (((i / dv) % 2) == 0) a = amp;
                else a = 16'd0 - amp;
                if (i < len - 1) begin
                    push(a, 1'b1, s, 1'b0);
                end else if (s == 31) begin
                    if (lp) begin
                        push(a, 1'b1, 0, 1'b0);
                        s = 0;
                    end else begin
                        push(a, 1'b0, 0, 1'b1);
                        push(16'd0, 1'b0, 0, 1'b0);
                        return;
                    end
                end else begin
                    push(a, 1'b1, s + 1, 1'b0);
                    s++;
                end
            end
        end
    endtask

    task automatic run(input string name, input bit lp, input int vol, input int max_rec);
        build(lp, vol, max_rec);
        loop   = lp;
        volume = 3'(vol);
        start  = 1'b1;
        tick();
        start = 1'b0;
        foreach (exp_q[k]) begin
            if (k > 0) tick();
            check($sformatf("%s[%0d].audio_l", name, k), 32'(audio_left), 32'(exp_q[k].audio));
            check($sformatf("%s[%0d].audio_r", name, k), 32'(audio_right), 32'(exp_q[k].audio));
            check($sformatf("%s[%0d].busy", name, k), 32'(busy), 32'(exp_q[k].busy));
            check($sformatf("%s[%0d].done", name, k), 32'(done), 32'(exp_q[k].done));
            if (exp_q[k].busy)
                check($sformatf("%s[%0d].step", name, k), 32'(step_idx), 32'(exp_q[k].step));
        end
        if (lp) begin
            stop = 1'b1;
            tick();
            stop = 1'b0;
            check({name, ".stop_audio"}, 32'(audio_left), 32'd0);
            check({name, ".stop_busy"}, 32'(busy), 32'd0);
            check({name, ".stop_done"}, 32'(done), 32'd0);
            tick();
            check({name, ".stop_done2"}, 32'(done), 32'd0);
        end
        loop = 1'b0;
    endtask

    initial begin
        int len;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; stop = 1'b0; loop = 1'b0; volume = '0;
        for (int i = 0; i < 32; i++) ram_m[i] = '0;
        tick();
        tick();
        check("rst.audio_l", 32'(audio_left), 32'd0);
        check("rst.audio_r", 32'(audio_right), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.step", 32'(step_idx), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        rst = 1'b0;
        tick();

        wr(0, 4, 1);
        wr(1, 0, 1);
        wr(2, 0, 0);
        run("basic", 1'b0, 4, 5000);
        run("loop", 1'b1, 4, 60);

        wr(0, 4, 2);
        wr(1, 0, 0);
        run("vol1", 1'b0, 1, 5000);
        run("vol7", 1'b0, 7, 5000);

        // Stop during the third PLAY cycle.
        volume = 3'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("stop.pre_audio", 32'(audio_left), 32'h4000);
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop.audio", 32'(audio_left), 32'd0);
        check("stop.busy", 32'(busy), 32'd0);
        check("stop.done", 32'(done), 32'd0);
        tick();
        check("stop.done2", 32'(done), 32'd0);

        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("startstop.busy", 32'(busy), 32'd0);
        tick();
        check("startstop.busy2", 32'(busy), 32'd0);
        check("startstop.audio", 32'(audio_left), 32'd0);

        // Mute mid-note.
        volume = 3'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("mute.pre_audio", 32'(audio_left), 32'h4000);
        volume = 3'd0;
        tick();
        check("mute.audio", 32'(audio_left), 32'd0);
        check("mute.busy", 32'(busy), 32'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();

        for (int a = 0; a < 32; a++) wr(a, 2, 1);
        run("fullram", 1'b0, 3, 5000);

        repeat (6) begin
            bit lp;
            len = int'($urandom_range(1, 5));
            for (int e = 0; e < len; e++)
                wr(e, int'($urandom_range(0, 5)), int'($urandom_range(1, 3)));
            wr(len, int'($urandom_range(0, 7)), 0);
            lp = 1'($urandom_range(0, 1));
            run("rand", lp, int'($urandom_range(0, 7)), lp ? 150 : 5000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
